tcm_memory: RTL and testbench

- Dual-ported, tightly-coupled 128 KB RAM feeding the dual-issue RISC-V core.
- Instruction port returns 64-bit fetch groups; data port services 32-bit loads and stores with byte strobes and request tags.
- Sits directly beside the core in the top level, with no cache in between.
- Supports simulation backdoor preload through a task.

---
 rtl/tcm_memory_pkg.sv | 14 +
 rtl/tcm_memory_ram_dp.sv | 54 +++++
 rtl/tcm_memory.sv | 111 +++++++++++
 tb/tb_tcm_memory.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tcm_memory_pkg.sv
// Shared constants and helpers for the tightly-coupled memory.
package tcm_memory_pkg;

  localparam int TCM_MEM_SIZE_BYTES = 131072;
  localparam int TCM_TAG_W          = 11;
  localparam int TCM_FETCH_W        = 64;
  localparam int TCM_DATA_W         = 32;

  // Place a 4-bit store strobe into the low or high half of a 64-bit word.
  function automatic logic [7:0] lane_be(input logic hi, input logic [3:0] strb);
    return hi ? {strb, 4'b0000} : {4'b0000, strb};
  endfunction

endpackage

// File: rtl/tcm_memory_ram_dp.sv
// True dual-port 64-bit RAM: port A read-only, port B read plus per-byte write.
// Both ports return the contents from before a same-edge write.
module tcm_ram_dp #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_en_i,
  input  logic [ADDR_W-1:0]     a_addr_i,
  output logic [DATA_W-1:0]     a_rdata_o,
  input  logic                  b_en_i,
  input  logic [DATA_W/8-1:0]   b_we_i,
  input  logic [ADDR_W-1:0]     b_addr_i,
  input  logic [DATA_W-1:0]     b_wdata_i,
  output logic [DATA_W-1:0]     b_rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Byte-masked write on port B. Plain always so the backdoor task may also
  // update the array; both writers use non-blocking updates.
  always @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (b_we_i[k]) ram[b_addr_i][k*8 +: 8] <= b_wdata_i[k*8 +: 8];
    end
  end

  // Registered reads; they sample the array before this edge's write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= ram[a_addr_i];
      if (b_en_i) b_rdata_q <= ram[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

  // Simulation backdoor: set one byte of one word without a clock edge.
  task write_byte(input logic [ADDR_W-1:0] widx, input logic [2:0] lane,
                  input logic [7:0] data);
    ram[widx][lane*8 +: 8] <= data;
  endtask

endmodule

// File: rtl/tcm_memory.sv
// Tightly-coupled 128 KB RAM: 64-bit fetch port and 32-bit tagged data port,
// single-cycle response, no backpressure.
module tcm_memory
  import tcm_memory_pkg::*;
#(
  parameter int MEM_SIZE_BYTES = TCM_MEM_SIZE_BYTES,
  parameter int WORD_ADDR_W    = $clog2(MEM_SIZE_BYTES / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_i_rd_i,
  input  logic                   mem_i_flush_i,
  input  logic                   mem_i_invalidate_i,
  input  logic [31:0]            mem_i_pc_i,
  output logic                   mem_i_accept_o,
  output logic                   mem_i_valid_o,
  output logic                   mem_i_error_o,
  output logic [TCM_FETCH_W-1:0] mem_i_inst_o,
  input  logic [31:0]            mem_d_addr_i,
  input  logic [31:0]            mem_d_data_wr_i,
  input  logic                   mem_d_rd_i,
  input  logic [3:0]             mem_d_wr_i,
  input  logic                   mem_d_cacheable_i,
  input  logic [TCM_TAG_W-1:0]   mem_d_req_tag_i,
  input  logic                   mem_d_invalidate_i,
  input  logic                   mem_d_writeback_i,
  input  logic                   mem_d_flush_i,
  output logic [31:0]            mem_d_data_rd_o,
  output logic                   mem_d_accept_o,
  output logic                   mem_d_ack_o,
  output logic                   mem_d_error_o,
  output logic [TCM_TAG_W-1:0]   mem_d_resp_tag_o
);

  logic                   d_req;
  logic [7:0]             b_we;
  logic [TCM_FETCH_W-1:0] b_rdata;

  logic                   i_valid_q, i_valid_d;
  logic                   d_ack_q,   d_ack_d;
  logic [TCM_TAG_W-1:0]   d_tag_q,   d_tag_d;
  logic                   d_hi_q,    d_hi_d;

  assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                 mem_d_invalidate_i | mem_d_writeback_i;

  // Requests during reset are dropped, so writes are gated here too.
  assign b_we = rst_i ? 8'h00 : lane_be(mem_d_addr_i[2], mem_d_wr_i);

  tcm_ram_dp #(
    .ADDR_W (WORD_ADDR_W),
    .DATA_W (TCM_FETCH_W)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .a_en_i    (mem_i_rd_i),
    .a_addr_i  (mem_i_pc_i[WORD_ADDR_W+2:3]),
    .a_rdata_o (mem_i_inst_o),
    .b_en_i    (mem_d_rd_i),
    .b_we_i    (b_we),
    .b_addr_i  (mem_d_addr_i[WORD_ADDR_W+2:3]),
    .b_wdata_i ({mem_d_data_wr_i, mem_d_data_wr_i}),
    .b_rdata_o (b_rdata)
  );

  // Next-state for the response flags; tag and half-select hold when idle
  // so the load data output stays stable between acks.
  always_comb begin
    i_valid_d = mem_i_rd_i;
    d_ack_d   = d_req;
    d_tag_d   = d_tag_q;
    d_hi_d    = d_hi_q;
    if (d_req)      d_tag_d = mem_d_req_tag_i;
    if (mem_d_rd_i) d_hi_d  = mem_d_addr_i[2];
  end

  // Response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_valid_q <= 1'b0;
      d_ack_q   <= 1'b0;
      d_tag_q   <= '0;
      d_hi_q    <= 1'b0;
    end else begin
      i_valid_q <= i_valid_d;
      d_ack_q   <= d_ack_d;
      d_tag_q   <= d_tag_d;
      d_hi_q    <= d_hi_d;
    end
  end

  assign mem_i_accept_o   = 1'b1;
  assign mem_i_valid_o    = i_valid_q;
  assign mem_i_error_o    = 1'b0;
  assign mem_d_accept_o   = 1'b1;
  assign mem_d_ack_o      = d_ack_q;
  assign mem_d_error_o    = 1'b0;
  assign mem_d_resp_tag_o = d_tag_q;
  assign mem_d_data_rd_o  = d_hi_q ? b_rdata[63:32] : b_rdata[31:0];

  // Inputs the memory has no use for; address bits outside the word index too.
  logic unused_ok;
  assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                       mem_i_pc_i, mem_d_addr_i};

  // Simulation backdoor: set byte addr[2:0] of word addr[WORD_ADDR_W+2:3].
  task write(input logic [31:0] addr, input logic [7:0] data);
    u_ram.write_byte(addr[WORD_ADDR_W+2:3], addr[2:0], data);
  endtask

endmodule

// File: tb/tb_tcm_memory.sv
// Directed bench for tcm_memory: fetch, store strobes, collisions, tagged
// back-to-back loads, maintenance acks and reset behaviour.
module tb_tcm_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd, i_flush, i_inv;
  logic [31:0] i_pc;
  logic        i_accept, i_valid, i_error;
  logic [63:0] i_inst;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_rd;
  logic [3:0]  d_wr;
  logic        d_cache;
  logic [10:0] d_tag, d_rtag;
  logic        d_inv, d_wb, d_flush;
  logic        d_accept, d_ack, d_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tcm_memory dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_i_rd_i         (i_rd),
    .mem_i_flush_i      (i_flush),
    .mem_i_invalidate_i (i_inv),
    .mem_i_pc_i         (i_pc),
    .mem_i_accept_o     (i_accept),
    .mem_i_valid_o      (i_valid),
    .mem_i_error_o      (i_error),
    .mem_i_inst_o       (i_inst),
    .mem_d_addr_i       (d_addr),
    .mem_d_data_wr_i    (d_wdata),
    .mem_d_rd_i         (d_rd),
    .mem_d_wr_i         (d_wr),
    .mem_d_cacheable_i  (d_cache),
    .mem_d_req_tag_i    (d_tag),
    .mem_d_invalidate_i (d_inv),
    .mem_d_writeback_i  (d_wb),
    .mem_d_flush_i      (d_flush),
    .mem_d_data_rd_o    (d_rdata),
    .mem_d_accept_o     (d_accept),
    .mem_d_ack_o        (d_ack),
    .mem_d_error_o      (d_error),
    .mem_d_resp_tag_o   (d_rtag)
  );

  task tick();
    @(posedge clk);
    #1;
  endtask

  task idle();
    i_rd = 0; i_flush = 0; i_inv = 0; i_pc = '0;
    d_addr = '0; d_wdata = '0; d_rd = 0; d_wr = '0; d_cache = 0;
    d_tag = '0; d_inv = 0; d_wb = 0; d_flush = 0;
  endtask

  task test_reset();
    rst = 1; idle();
    tick(); tick();
    tests++; if (i_valid !== 1'b0)  begin fails++; $display("FAIL reset_valid got %b exp 0", i_valid); end
    tests++; if (d_ack !== 1'b0)    begin fails++; $display("FAIL reset_ack got %b exp 0", d_ack); end
    tests++; if (d_rtag !== 11'h0)  begin fails++; $display("FAIL reset_tag got %h exp 0", d_rtag); end
    tests++; if (d_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", d_rdata); end
    tests++; if (i_inst !== 64'h0)  begin fails++; $display("FAIL reset_inst got %h exp 0", i_inst); end
    tests++; if ({i_accept, d_accept, i_error, d_error} !== 4'b1100)
      begin fails++; $display("FAIL reset_const got %b exp 1100", {i_accept, d_accept, i_error, d_error}); end
    rst = 0;
    tick();
  endtask

  task test_fetch();
    for (int b = 0; b < 16; b++) dut.write(32'h8000_0000 + b, 8'(b));
    for (int b = 0; b < 8; b++)  dut.write(32'h0000_0010 + b, 8'h5A);
    #1;
    i_rd = 1; i_pc = 32'h8000_0000;
    tick();
    tests++; if (i_valid !== 1'b1) begin fails++; $display("FAIL fetch0_valid got %b exp 1", i_valid); end
    tests++; if (i_inst !== 64'h0706050403020100) begin fails++; $display("FAIL fetch0_inst got %h exp 0706050403020100", i_inst); end
    i_pc = 32'h8000_0004;
    tick();
    tests++; if (i_inst !== 64'h0706050403020100) begin fails++; $display("FAIL fetch4_inst got %h exp 0706050403020100", i_inst); end
    i_pc = 32'h8000_0008;
    tick();
    tests++; if (i_inst !== 64'h0F0E0D0C0B0A0908) begin fails++; $display("FAIL fetch8_inst got %h exp 0F0E0D0C0B0A0908", i_inst); end
    i_rd = 0;
    tick();
    tests++; if (i_valid !== 1'b0) begin fails++; $display("FAIL fetch_idle_valid got %b exp 0", i_valid); end
  endtask

  task test_store();
    d_addr = 32'h8000_0000; d_wdata = 32'hAAAA_AAAA; d_wr = 4'hF; d_tag = 11'h123;
    tick();
    idle();
    tests++; if (d_ack !== 1'b1)   begin fails++; $display("FAIL store_ack got %b exp 1", d_ack); end
    tests++; if (d_rtag !== 11'h123) begin fails++; $display("FAIL store_tag got %h exp 123", d_rtag); end
    tests++; if (dut.u_ram.ram[0] !== 64'h07060504_AAAAAAAA)
      begin fails++; $display("FAIL store_ram got %h exp 07060504AAAAAAAA", dut.u_ram.ram[0]); end
    tick();
    tests++; if (d_ack !== 1'b0) begin fails++; $display("FAIL store_ack_drop got %b exp 0", d_ack); end
  endtask

  task test_strobe();
    d_addr = 32'h8000_0004; d_wdata = 32'h1122_3344; d_wr = 4'h4; d_tag = 11'h010;
    tick();
    idle();
    d_addr = 32'h8000_0004; d_rd = 1; d_tag = 11'h005;
    tests++; if (dut.u_ram.ram[0] !== 64'h07220504_AAAAAAAA)
      begin fails++; $display("FAIL strobe_ram got %h exp 07220504AAAAAAAA", dut.u_ram.ram[0]); end
    tick();
    idle();
    tests++; if (d_ack !== 1'b1 || d_rtag !== 11'h005)
      begin fails++; $display("FAIL strobe_load_ack got %b/%h exp 1/005", d_ack, d_rtag); end
    tests++; if (d_rdata !== 32'h0722_0504) begin fails++; $display("FAIL strobe_load_data got %h exp 07220504", d_rdata); end
    tick();
    tests++; if (d_rdata !== 32'h0722_0504) begin fails++; $display("FAIL load_hold got %h exp 07220504", d_rdata); end
  endtask

  task test_collision();
    i_rd = 1; i_pc = 32'h0000_0008;
    d_addr = 32'h0000_000C; d_wdata = 32'hDEAD_BEEF; d_wr = 4'hF; d_rd = 1; d_tag = 11'h042;
    tick();
    idle();
    tests++; if (i_inst !== 64'h0F0E0D0C0B0A0908) begin fails++; $display("FAIL coll_fetch got %h exp 0F0E0D0C0B0A0908", i_inst); end
    tests++; if (d_rdata !== 32'h0F0E_0D0C) begin fails++; $display("FAIL coll_load got %h exp 0F0E0D0C", d_rdata); end
    i_rd = 1; i_pc = 32'h8000_000C;
    tick();
    idle();
    tests++; if (i_inst !== 64'hDEADBEEF_0B0A0908) begin fails++; $display("FAIL coll_refetch got %h exp DEADBEEF0B0A0908", i_inst); end
  endtask

  task test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp   [3];
    addrs = '{32'h0000_0000, 32'h0000_0004, 32'h0000_000C};
    exp   = '{32'hAAAA_AAAA, 32'h0722_0504, 32'hDEAD_BEEF};
    for (int n = 0; n < 3; n++) begin
      d_rd = 1; d_addr = addrs[n]; d_tag = 11'(n + 1);
      tick();
      tests++;
      if (d_ack !== 1'b1 || d_rtag !== 11'(n + 1) || d_rdata !== exp[n] || d_accept !== 1'b1)
        begin fails++; $display("FAIL b2b_%0d got ack=%b tag=%h data=%h acc=%b exp 1/%h/%h/1",
                                n, d_ack, d_rtag, d_rdata, d_accept, 11'(n + 1), exp[n]); end
    end
    idle();
    tick();
  endtask

  task test_maint();
    d_flush = 1; d_addr = 32'h0000_0000; d_wdata = 32'h5555_5555; d_tag = 11'h7FF;
    tick();
    d_flush = 0; d_wb = 1; d_tag = 11'h0AB;
    tests++; if (d_ack !== 1'b1 || d_rtag !== 11'h7FF)
      begin fails++; $display("FAIL flush_ack got %b/%h exp 1/7FF", d_ack, d_rtag); end
    tick();
    idle();
    tests++; if (d_ack !== 1'b1 || d_rtag !== 11'h0AB)
      begin fails++; $display("FAIL wb_ack got %b/%h exp 1/0AB", d_ack, d_rtag); end
    tests++; if (dut.u_ram.ram[0] !== 64'h07220504_AAAAAAAA)
      begin fails++; $display("FAIL maint_ram got %h exp 07220504AAAAAAAA", dut.u_ram.ram[0]); end
    tick();
  endtask

  task test_reset_mid();
    d_rd = 1; d_addr = 32'h0000_0004; d_tag = 11'h004; i_rd = 1; i_pc = 32'h0;
    tick();
    tests++; if (d_ack !== 1'b1) begin fails++; $display("FAIL pre_rst_ack got %b exp 1", d_ack); end
    rst = 1;
    d_wr = 4'hF; d_addr = 32'h0000_0010; d_wdata = 32'h1234_5678; d_tag = 11'h055;
    tick();
    tests++; if (d_ack !== 1'b0 || i_valid !== 1'b0 || d_rtag !== 11'h0)
      begin fails++; $display("FAIL rst_mid got ack=%b valid=%b tag=%h exp 0/0/0", d_ack, i_valid, d_rtag); end
    tests++; if (d_rdata !== 32'h0 || i_inst !== 64'h0)
      begin fails++; $display("FAIL rst_mid_data got %h/%h exp 0/0", d_rdata, i_inst); end
    rst = 0; idle();
    tick();
    tests++; if (d_ack !== 1'b0) begin fails++; $display("FAIL rst_drop_ack got %b exp 0", d_ack); end
    tests++; if (dut.u_ram.ram[2] !== 64'h5A5A5A5A_5A5A5A5A)
      begin fails++; $display("FAIL rst_no_write got %h exp 5A5A5A5A5A5A5A5A", dut.u_ram.ram[2]); end
    i_rd = 1; i_pc = 32'h8000_0000;
    tick();
    idle();
    tests++; if (i_valid !== 1'b1 || i_inst !== 64'h07220504_AAAAAAAA)
      begin fails++; $display("FAIL post_rst_fetch got %b/%h exp 1/07220504AAAAAAAA", i_valid, i_inst); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_strobe();
    test_collision();
    test_back_to_back();
    test_maint();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
